pe_mac_simd: RTL and testbench

Parametrised successor processing element for the systolic matrix-multiply array. Each beat, the block multiplies LANES packed operand pairs and adds them into a running accumulator. It forwards both operand buses to its east and south neighbours through one register stage. It adds valid/ready flow control, signed or unsigned mode, optional saturation, and a held result output drained by handshake, so dot products of any length stream back-to-back.

---
 rtl/pe_pkg.sv | 38 +++
 rtl/pe_mac_simd_lane_mul.sv | 38 +++
 rtl/pe_mac_simd.sv | 148 ++++++++++++++
 tb/tb_pe_mac_simd.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared types, default sizes and helpers for the MAC processing element.
//   dtype_e      : element data-type encodings
//   DEF_*        : default element width, lane count, accumulator width
//   lane_lsb()   : bit offset of a lane inside a packed operand bus
//   sat_limit()  : clamp value for a given accumulator width and mode
package pe_pkg;

  typedef enum logic [2:0] {
    DT_INT8  = 3'b011,
    DT_INT16 = 3'b100,
    DT_INT32 = 3'b101
  } dtype_e;

  localparam int unsigned DEF_DW    = 8;
  localparam int unsigned DEF_LANES = 4;
  localparam int unsigned DEF_ACC_W = 2 * DEF_DW + $clog2(DEF_LANES) + 16;

  // Widest accumulator the clamp helper can describe.
  localparam int unsigned MAX_ACC_W = 128;

  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned dw);
    return lane * dw;
  endfunction

  // Unsigned: all ones. Signed: max positive, or min negative when neg is set.
  function automatic logic [MAX_ACC_W-1:0] sat_limit(input int unsigned w,
                                                     input logic        is_signed,
                                                     input logic        neg);
    logic [MAX_ACC_W-1:0] lim;
    lim = '0;
    for (int unsigned i = 0; i < MAX_ACC_W; i++) begin
      if (i + 1 < w)       lim[i] = !(is_signed && neg);
      else if (i + 1 == w) lim[i] = !is_signed || neg;
    end
    return lim;
  endfunction

endpackage

// File: rtl/pe_mac_simd_lane_mul.sv
// One DW x DW multiplier lane with a registered 2*DW product.
//   clk, rst        : clock, synchronous active-high reset
//   en_i            : capture enable (low while the pipeline is stalled)
//   a_i, b_i        : operands
//   signed_mode_i   : 1 = operands are two's complement
//   prod_o          : registered product, 2*DW bits
module pe_lane_mul
  import pe_pkg::*;
#(
  parameter int unsigned DW = DEF_DW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en_i,
  input  logic [DW-1:0]   a_i,
  input  logic [DW-1:0]   b_i,
  input  logic            signed_mode_i,
  output logic [2*DW-1:0] prod_o
);

  logic [2*DW-1:0] a_x;
  logic [2*DW-1:0] b_x;
  logic [2*DW-1:0] prod_d;
  logic [2*DW-1:0] prod_q;

  // Extending to 2*DW first makes the truncated product exact for both modes.
  assign a_x    = {{DW{signed_mode_i & a_i[DW-1]}}, a_i};
  assign b_x    = {{DW{signed_mode_i & b_i[DW-1]}}, b_i};
  assign prod_d = a_x * b_x;

  always_ff @(posedge clk) begin
    if (rst)       prod_q <= '0;
    else if (en_i) prod_q <= prod_d;
  end

  assign prod_o = prod_q;

endmodule

// File: rtl/pe_mac_simd.sv
// SIMD multiply-accumulate processing element for a systolic array.
//   clk, rst                  : clock, synchronous active-high reset
//   in_valid/in_ready         : operand beat handshake
//   mat1, mat2                : packed row/column operands, lane i at [i*DW +: DW]
//   first, last, signed_mode  : per-beat dot-product framing and element mode
//   outp_row/outp_col/outp_valid : operands forwarded east/south, 1-cycle latency
//   result/result_valid/result_ready : held dot product, drained by handshake
//   ovf                       : overflow occurred within the held result
module pe_mac_simd
  import pe_pkg::*;
#(
  parameter int unsigned DW    = DEF_DW,
  parameter int unsigned LANES = DEF_LANES,
  parameter int unsigned ACC_W = 2 * DW + $clog2(LANES) + 16,
  parameter bit          SAT   = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [LANES*DW-1:0] mat1,
  input  logic [LANES*DW-1:0] mat2,
  input  logic                first,
  input  logic                last,
  input  logic                signed_mode,
  output logic [LANES*DW-1:0] outp_row,
  output logic [LANES*DW-1:0] outp_col,
  output logic                outp_valid,
  output logic [ACC_W-1:0]    result,
  output logic                result_valid,
  input  logic                result_ready,
  output logic                ovf
);

  logic stall_c;
  logic accept_c;

  logic [LANES*DW-1:0] row_q, col_q;
  logic                outp_valid_q;
  logic                s1_valid_q, s1_first_q, s1_last_q, s1_signed_q;
  logic [2*DW-1:0]     prod [LANES];

  logic [ACC_W-1:0] acc_q, acc_d;
  logic             acc_ovf_q, acc_ovf_d;
  logic [ACC_W-1:0] result_q, result_d;
  logic             result_valid_q, result_valid_d;
  logic             ovf_q, ovf_d;

  logic [ACC_W-1:0] sum_c;
  logic [ACC_W-1:0] base_c;
  logic [ACC_W:0]   add_c;
  logic             add_ovf_c;
  logic [ACC_W-1:0] acc_next_c;

  // A held, unconsumed result freezes the whole element.
  assign stall_c  = result_valid_q && !result_ready;
  assign accept_c = in_valid && !stall_c;
  assign in_ready = !stall_c;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    pe_lane_mul #(.DW(DW)) u_mul (
      .clk           (clk),
      .rst           (rst),
      .en_i          (!stall_c),
      .a_i           (mat1[lane_lsb(i, DW) +: DW]),
      .b_i           (mat2[lane_lsb(i, DW) +: DW]),
      .signed_mode_i (signed_mode),
      .prod_o        (prod[i])
    );
  end

  // S2: lane reduction, accumulate with mode-aware overflow and optional clamp.
  always_comb begin
    sum_c = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      sum_c = sum_c + {{(ACC_W-2*DW){s1_signed_q & prod[i][2*DW-1]}}, prod[i]};
    end
    base_c = s1_first_q ? '0 : acc_q;
    add_c  = {1'b0, base_c} + {1'b0, sum_c};
    if (s1_signed_q)
      add_ovf_c = (base_c[ACC_W-1] == sum_c[ACC_W-1]) && (add_c[ACC_W-1] != base_c[ACC_W-1]);
    else
      add_ovf_c = add_c[ACC_W];
    // Signed overflow needs equal operand signs, so the base sign picks the rail.
    if (SAT && add_ovf_c)
      acc_next_c = ACC_W'(sat_limit(ACC_W, s1_signed_q, base_c[ACC_W-1]));
    else
      acc_next_c = add_c[ACC_W-1:0];
  end

  // Next-state for accumulator and result; ovf drops when the result is drained.
  always_comb begin
    acc_d          = acc_q;
    acc_ovf_d      = acc_ovf_q;
    result_d       = result_q;
    result_valid_d = 1'b0;
    ovf_d          = 1'b0;
    if (s1_valid_q) begin
      acc_d     = acc_next_c;
      acc_ovf_d = (!s1_first_q && acc_ovf_q) || add_ovf_c;
      if (s1_last_q) begin
        result_d       = acc_next_c;
        result_valid_d = 1'b1;
        ovf_d          = acc_ovf_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q          <= '0;
      col_q          <= '0;
      outp_valid_q   <= 1'b0;
      s1_valid_q     <= 1'b0;
      s1_first_q     <= 1'b0;
      s1_last_q      <= 1'b0;
      s1_signed_q    <= 1'b0;
      acc_q          <= '0;
      acc_ovf_q      <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      ovf_q          <= 1'b0;
    end else if (!stall_c) begin
      outp_valid_q <= accept_c;
      if (accept_c) begin
        row_q <= mat1;
        col_q <= mat2;
      end
      s1_valid_q     <= accept_c;
      s1_first_q     <= first;
      s1_last_q      <= last;
      s1_signed_q    <= signed_mode;
      acc_q          <= acc_d;
      acc_ovf_q      <= acc_ovf_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      ovf_q          <= ovf_d;
    end
  end

  assign outp_row     = row_q;
  assign outp_col     = col_q;
  assign outp_valid   = outp_valid_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign ovf          = ovf_q;

endmodule

// File: tb/tb_pe_mac_simd.sv
// Directed bench: default instance plus two 18-bit accumulator instances
// (clamping and wrapping) driven by the same stimulus.
module tb_pe_mac_simd;

  localparam int unsigned DW    = 8;
  localparam int unsigned LANES = 4;
  localparam int unsigned BW    = DW * LANES;
  localparam int unsigned AW    = 34;
  localparam int unsigned NW    = 18;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [BW-1:0] mat1, mat2;
  logic          first, last, signed_mode;
  logic          result_ready;

  logic          d_in_ready, s_in_ready, w_in_ready;
  logic [BW-1:0] d_row, d_col, s_row, s_col, w_row, w_col;
  logic          d_ov, s_ov, w_ov;
  logic [AW-1:0] d_res;
  logic [NW-1:0] s_res, w_res;
  logic          d_rv, s_rv, w_rv;
  logic          d_ovf, s_ovf, w_ovf;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  pe_mac_simd #(.DW(DW), .LANES(LANES)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d_in_ready),
    .mat1(mat1), .mat2(mat2), .first(first), .last(last), .signed_mode(signed_mode),
    .outp_row(d_row), .outp_col(d_col), .outp_valid(d_ov),
    .result(d_res), .result_valid(d_rv), .result_ready(result_ready), .ovf(d_ovf)
  );

  pe_mac_simd #(.DW(DW), .LANES(LANES), .ACC_W(NW), .SAT(1'b1)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
    .mat1(mat1), .mat2(mat2), .first(first), .last(last), .signed_mode(signed_mode),
    .outp_row(s_row), .outp_col(s_col), .outp_valid(s_ov),
    .result(s_res), .result_valid(s_rv), .result_ready(result_ready), .ovf(s_ovf)
  );

  pe_mac_simd #(.DW(DW), .LANES(LANES), .ACC_W(NW), .SAT(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready),
    .mat1(mat1), .mat2(mat2), .first(first), .last(last), .signed_mode(signed_mode),
    .outp_row(w_row), .outp_col(w_col), .outp_valid(w_ov),
    .result(w_res), .result_valid(w_rv), .result_ready(result_ready), .ovf(w_ovf)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [BW-1:0] a, input logic [BW-1:0] b,
                       input logic f, input logic l, input logic sm);
    in_valid    = v;
    mat1        = a;
    mat2        = b;
    first       = f;
    last        = l;
    signed_mode = sm;
  endtask

  initial begin
    rst          = 1'b1;
    result_ready = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();

    // Reset state of every instance
    check("rst_in_ready",   64'(d_in_ready & s_in_ready & w_in_ready), 64'd1);
    check("rst_outp_valid", 64'(d_ov | s_ov | w_ov), 64'd0);
    check("rst_outp_data",  64'(d_row | d_col | s_row | s_col | w_row | w_col), 64'd0);
    check("rst_result",     64'(d_res) | 64'(s_res) | 64'(w_res), 64'd0);
    check("rst_rv_ovf",     64'(d_rv | s_rv | w_rv | d_ovf | s_ovf | w_ovf), 64'd0);
    rst = 1'b0;

    // 1: single beat, unsigned, {1,2,3,4}.{5,6,7,8} = 70
    drive(1'b1, 32'h04030201, 32'h08070605, 1'b1, 1'b1, 1'b0);
    tick();
    check("t1_outp_row",   64'(d_row), 64'h04030201);
    check("t1_outp_col",   64'(d_col), 64'h08070605);
    check("t1_outp_valid", 64'(d_ov), 64'd1);
    check("t1_rv_early",   64'(d_rv), 64'd0);
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    tick();
    check("t1_result",     64'(d_res), 64'd70);
    check("t1_rv",         64'(d_rv), 64'd1);
    check("t1_ovf",        64'(d_ovf), 64'd0);
    check("t1_bubble_ov",  64'(d_ov), 64'd0);
    check("t1_row_hold",   64'(d_row), 64'h04030201);
    tick();
    check("t1_rv_drained", 64'(d_rv), 64'd0);

    // 2: three-beat dot product then an independent single beat back-to-back
    drive(1'b1, 32'h02020202, 32'h03030303, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h0A0A0A0A, 32'h0B0B0B0B, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h07070707, 32'h08080808, 1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b1, 32'h01010101, 32'h01010101, 1'b1, 1'b1, 1'b0);
    tick();
    check("t2_result", 64'(d_res), 64'd688);
    check("t2_rv",     64'(d_rv), 64'd1);
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    tick();
    check("t2_b2b_result", 64'(d_res), 64'd4);
    check("t2_b2b_rv",     64'(d_rv), 64'd1);

    // 3: signed (-1 x 1) x4 = -4, then unsigned same data = 1020
    drive(1'b1, 32'hFFFFFFFF, 32'h01010101, 1'b1, 1'b1, 1'b1);
    tick();
    drive(1'b1, 32'hFFFFFFFF, 32'h01010101, 1'b1, 1'b1, 1'b0);
    tick();
    check("t3_signed",        64'(d_res), 64'h3_FFFF_FFFC);
    check("t3_signed_narrow", 64'(w_res), 64'h3FFFC);
    check("t3_signed_ovf",    64'(d_ovf), 64'd0);
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    tick();
    check("t3_unsigned", 64'(d_res), 64'd1020);
    tick();

    // 4: back-pressure holds the result and blocks new beats
    result_ready = 1'b0;
    drive(1'b1, 32'h04030201, 32'h08070605, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    tick();
    check("t4_held_rv",  64'(d_rv), 64'd1);
    check("t4_in_ready", 64'(d_in_ready), 64'd0);
    drive(1'b1, 32'h02020202, 32'h03030303, 1'b1, 1'b0, 1'b0);
    tick();
    check("t4_stall_ov",     64'(d_ov), 64'd0);
    check("t4_stall_result", 64'(d_res), 64'd70);
    tick();
    check("t4_stall_ov2", 64'(d_ov), 64'd0);
    check("t4_stall_rdy", 64'(d_in_ready), 64'd0);
    result_ready = 1'b1;
    tick();
    check("t4_resume_ov",  64'(d_ov), 64'd1);
    check("t4_resume_row", 64'(d_row), 64'h02020202);
    check("t4_drained_rv", 64'(d_rv), 64'd0);
    drive(1'b1, 32'h0A0A0A0A, 32'h0B0B0B0B, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h07070707, 32'h08080808, 1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    tick();
    check("t4_result", 64'(d_res), 64'd688);
    check("t4_rv",     64'(d_rv), 64'd1);
    tick();

    // 5: 18-bit accumulators overflow on 2 x 260100
    drive(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    tick();
    check("t5_sat_result",  64'(s_res), 64'd262143);
    check("t5_sat_ovf",     64'(s_ovf), 64'd1);
    check("t5_wrap_result", 64'(w_res), 64'd258056);
    check("t5_wrap_ovf",    64'(w_ovf), 64'd1);
    check("t5_wide_result", 64'(d_res), 64'd520200);
    check("t5_wide_ovf",    64'(d_ovf), 64'd0);
    tick();

    // 6: reset mid dot product discards the partial sum
    drive(1'b1, 32'h02020202, 32'h03030303, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h0A0A0A0A, 32'h0B0B0B0B, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    check("t6_rst_ov",     64'(d_ov), 64'd0);
    check("t6_rst_row",    64'(d_row), 64'd0);
    check("t6_rst_rv",     64'(d_rv), 64'd0);
    check("t6_rst_result", 64'(d_res), 64'd0);
    rst = 1'b0;
    // Continuation beat (no first) must build on a zeroed accumulator.
    drive(1'b1, 32'h04030201, 32'h08070605, 1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    tick();
    check("t6_clean_result", 64'(d_res), 64'd70);
    check("t6_clean_rv",     64'(d_rv), 64'd1);
    check("t6_clean_ovf",    64'(d_ovf), 64'd0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
